// File: rtl/linescanner_pkg.sv
// Shared linescanner definitions: FSM state encoding and default timing
// parameters, common to the sensor emulator and the capture unit.
package linescanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_READOUT = 2'd2,
    ST_BLANK   = 2'd3
  } ls_state_t;

  localparam int DEF_PIXELS_PER_LINE = 1024;
  localparam int DEF_ADC_CLOCKS      = 16;
  localparam int DEF_LINE_BLANK      = 4;

  // Wide enough for the largest phase length (4096 pixels).
  localparam int CNT_W = 13;

endpackage

// File: rtl/linescanner_pattern_generator.sv
// Registered pixel value source: data = (pixel index + line number) mod 256,
// updated only when load is high so the value holds between lines.
module linescanner_pattern_generator (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] pixel_index,
  input  logic [7:0] line_lsb,
  output logic [7:0] data
);

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      data <= 8'd0;
    end else if (load) begin
      data <= pixel_index + line_lsb;
    end
  end

endmodule

// File: rtl/linescanner_sensor_emulator.sv
// Line-scan sensor emulator: sample strobe -> ADC conversion -> pixel readout
// -> line blanking, with exposure measurement and strobe-protocol checking.
module linescanner_sensor_emulator
  import linescanner_pkg::*;
#(
  parameter int PIXELS_PER_LINE = DEF_PIXELS_PER_LINE,
  parameter int ADC_CLOCKS      = DEF_ADC_CLOCKS,
  parameter int LINE_BLANK      = DEF_LINE_BLANK
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rst_cvc,
  input  logic        rst_cds,
  input  logic        sample,
  input  logic        clear_error,
  output logic        end_adc,
  output logic        lval,
  output logic [7:0]  data,
  output logic [15:0] line_count,
  output logic [15:0] last_exposure,
  output logic        protocol_error
);

  localparam logic [CNT_W-1:0] ADC_LAST   = CNT_W'(ADC_CLOCKS - 1);
  localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(PIXELS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((LINE_BLANK > 0) ? LINE_BLANK - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  ls_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             sample_q, rst_cvc_q;
  logic [15:0]      exposure, exposure_next;
  logic             sample_rise, cvc_fall;
  logic             accept, overrun, violation;
  logic             pix_load, line_done;
  logic [7:0]       pix_index;

  assign sample_rise = sample & ~sample_q;
  assign cvc_fall    = ~rst_cvc & rst_cvc_q;
  assign accept      = (state == ST_IDLE) & sample_rise & enable;
  assign overrun     = (state != ST_IDLE) & sample_rise;
  // A gated-off rise in IDLE is ignored entirely, strobe state included.
  assign violation   = sample_rise & (rst_cvc | rst_cds) & ((state != ST_IDLE) | enable);

  always_comb begin
    exposure_next = exposure;
    if (cvc_fall) begin
      exposure_next = 16'd0;
    end else if (!rst_cvc && exposure != 16'hFFFF) begin
      exposure_next = exposure + 16'd1;
    end
  end

  // The pattern generator is loaded one edge early with the index of the
  // pixel about to be shown, so data lines up with lval.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pix_load   = 1'b0;
    line_done  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_CONVERT;
          cnt_next   = '0;
        end
      end
      ST_CONVERT: begin
        if (cnt == ADC_LAST) begin
          state_next = ST_READOUT;
          cnt_next   = '0;
          pix_load   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      ST_READOUT: begin
        if (cnt == PIX_LAST) begin
          line_done  = 1'b1;
          cnt_next   = '0;
          state_next = (LINE_BLANK == 0) ? ST_IDLE : ST_BLANK;
        end else begin
          cnt_next = cnt + CNT_ONE;
          pix_load = 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign pix_index = cnt_next[7:0];

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      sample_q       <= 1'b0;
      rst_cvc_q      <= 1'b0;
      exposure       <= 16'd0;
      end_adc        <= 1'b1;
      lval           <= 1'b0;
      line_count     <= 16'd0;
      last_exposure  <= 16'd0;
      protocol_error <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      sample_q  <= sample;
      rst_cvc_q <= rst_cvc;
      exposure  <= exposure_next;
      end_adc   <= (state_next == ST_IDLE);
      lval      <= (state_next == ST_READOUT);
      if (line_done) begin
        line_count <= line_count + 16'd1;
      end
      if (accept) begin
        last_exposure <= exposure_next;
      end
      if (overrun || violation) begin
        protocol_error <= 1'b1;
      end else if (clear_error) begin
        protocol_error <= 1'b0;
      end
    end
  end

  linescanner_pattern_generator u_pattern (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .load        (pix_load),
    .pixel_index (pix_index),
    .line_lsb    (line_count[7:0]),
    .data        (data)
  );

endmodule

// File: doc/linescanner_sensor_emulator.md
LINESCANNER_SENSOR_EMULATOR -- requirements
Module: linescanner_sensor_emulator

Interface
REQ-001 Parameter PIXELS_PER_LINE, default 1024, sets pixels driven per line (range 1..4096).
REQ-002 Parameter ADC_CLOCKS, default 16, sets conversion cycles between sample rise and line start (range 1..255).
REQ-003 Parameter LINE_BLANK, default 4, sets cycles with lval low after a line before end_adc rises again (range 0..255).
REQ-004 pixel_clock  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  when low, new sample rises are not accepted.
REQ-007 rst_cvc  input  1  sensor pixel-reset strobe from the capture unit; synchronous to pixel_clock.
REQ-008 rst_cds  input  1  sensor CDS-reset strobe; synchronous to pixel_clock.
REQ-009 sample  input  1  sample strobe; rising edge starts conversion.
REQ-010 clear_error  input  1  one-cycle pulse clearing protocol_error.
REQ-011 end_adc  output  1  high when ready to accept a sample.
REQ-012 lval  output  1  line-valid; high during pixel readout.
REQ-013 data  output  8  pixel value, valid when lval is high.
REQ-014 line_count  output  16  completed-line counter.
REQ-015 last_exposure  output  16  cycles from the last rst_cvc fall to the accepted sample rise.
REQ-016 protocol_error  output  1  sticky strobe-sequence violation flag.

Function
REQ-017 Edge detection uses registered copies of rst_cvc and sample.
- Rise: current value 1, previous 0.
- Fall: current value 0, previous 1.
REQ-018 The FSM states are IDLE, CONVERT, READOUT and BLANK; all outputs are registered.
REQ-019 IDLE: end_adc=1, lval=0.
- Sample rise with enable=1 → next cycle: end_adc=0, state CONVERT.
REQ-020 CONVERT lasts exactly ADC_CLOCKS cycles, then the FSM enters READOUT.
REQ-021 READOUT holds lval=1 for exactly PIXELS_PER_LINE consecutive cycles.
- data on pixel k (k=0..PIXELS_PER_LINE-1) = (k + line_count[7:0]) mod 256.
REQ-022 On the last READOUT cycle's following edge:
- lval=0.
- line_count increments, wrapping at 16'hFFFF→0.
- State becomes BLANK.
REQ-023 BLANK lasts LINE_BLANK cycles (0 means straight to IDLE); on entry to IDLE, end_adc=1.
REQ-024 The exposure counter:
- clears to 0 on rst_cvc fall;
- increments every cycle while rst_cvc=0;
- saturates at 16'hFFFF;
- is copied to last_exposure on the accepted sample rise.
REQ-025 protocol_error sets on either event:
- a sample rise while rst_cvc=1 or rst_cds=1;
- a sample rise in any state other than IDLE (overrun).
The overrun rise is otherwise ignored.
REQ-026 Sample rise with enable=0 in IDLE: ignored, no error.
REQ-027 clear_error clears protocol_error next cycle; a simultaneous set condition wins (flag stays 1).
REQ-028 Deasserting enable mid-line does not abort the line in progress.
REQ-029 data holds its last value when lval=0.

Reset
REQ-030 Reset (at any time, including mid-line) forces the following asynchronously:
- state IDLE, end_adc=1, lval=0, data=0;
- line_count=0, last_exposure=0, protocol_error=0;
- exposure counter=0, edge registers=0.
REQ-031 After reset release, the first accepted sample rise yields lval high exactly ADC_CLOCKS+1 cycles later.

Structure
REQ-032 State encodings and default parameter values reside in a shared linescanner definitions include file, also used by the capture unit.
REQ-033 The pixel value function is one sub-module, linescanner_pattern_generator:
- inputs: pixel index, line_count[7:0];
- output: data;
- registered, with its latency absorbed in READOUT timing so REQ-021 holds exactly.

Verification (PIXELS_PER_LINE=8, ADC_CLOCKS=4, LINE_BLANK=2)
REQ-034 Nominal line: reset, rst_cvc/rst_cds low, sample rise at cycle 10:
- end_adc=0 at 11;
- lval=1 cycles 15..22 with data 0..7;
- end_adc=1 at 25;
- line_count=1.
REQ-035 Second line: data 1..8; after 256 lines, data restarts at 0.
REQ-036 Exposure: rst_cvc falls at cycle 0, sample rises at cycle 55 → last_exposure=55.
REQ-037 Overrun: sample rise during READOUT → protocol_error=1, line unaffected; clear_error → 0.
REQ-038 Violation and gating:
- Sample rise with rst_cds=1 → protocol_error=1.
- Sample rise with enable=0 → no conversion, end_adc stays 1.
REQ-039 Reset asserted at READOUT pixel 3 → lval=0 and end_adc=1 immediately; the next line starts at data 0.
